// File: rtl/fip_32_tri_hit.sv
// fip_32_tri_hit: resolves t/u/v from Cramer determinants through one shared
// restoring divider, then applies the barycentric and distance hit tests.
module fip_32_tri_hit #(
   parameter int FRA_BITS = 16,
   parameter int ID_W = 16,
   parameter logic signed [31:0] T_EPS = 32'sd1
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_en,
   input  logic signed [31:0]     i_det_a,
   input  logic signed [31:0]     i_det_t,
   input  logic signed [31:0]     i_det_u,
   input  logic signed [31:0]     i_det_v,
   input  logic [ID_W-1:0]        i_id,
   output logic signed [31:0]     o_t,
   output logic signed [31:0]     o_u,
   output logic signed [31:0]     o_v,
   output logic                   o_hit,
   output logic [ID_W-1:0]        o_id,
   output logic                   o_busy,
   output logic                   o_valid
);
   localparam int DW = 32 + FRA_BITS;
   localparam int CW = $clog2(DW);
   localparam logic signed [32:0] ONE = 33'sd1 <<< FRA_BITS;
   typedef enum logic [1:0] {IDLE, DIV, TEST} state_t;
   state_t state_q, state_d;
   logic signed [31:0] a_q, a_d, nt_q, nt_d, nu_q, nu_d, nv_q, nv_d;
   logic signed [31:0] rt_q, rt_d, ru_q, ru_d, rv_q, rv_d;
   logic signed [31:0] ot_q, ot_d, ou_q, ou_d, ov_q, ov_d;
   logic [31:0] rem_q, rem_d;
   logic [DW-1:0] dd_q, dd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic deg_q, deg_d, hit_q, hit_d, busy_q, busy_d, valid_q, valid_d;
   logic [ID_W-1:0] id_q, id_d, oid_q, oid_d;
   logic [32:0] trial, diff;
   logic ge, neg, last, hit;
   logic [DW-1:0] quo;
   logic signed [31:0] cur, nxt;
   logic [31:0] res;
   logic signed [32:0] uv;
   function automatic logic [31:0] mag(input logic signed [31:0] x);
      return x[31] ? 32'(-x) : 32'(x);
   endfunction
   assign trial = {rem_q, dd_q[DW-1]};
   assign diff  = trial - {1'b0, mag(a_q)};
   assign ge    = trial >= {1'b0, mag(a_q)};
   assign quo   = {dd_q[DW-2:0], ge};
   assign last  = cnt_q == CW'(DW - 1);
   assign cur   = idx_q == 2'd0 ? nt_q : idx_q == 2'd1 ? nu_q : nv_q;
   assign nxt   = idx_q == 2'd0 ? nu_q : nv_q;
   assign neg   = cur[31] ^ a_q[31];
   // Magnitude is clamped to the signed range before the sign is applied
   assign res   = neg ? (quo > DW'(33'h080000000) ? 32'h80000000 : -quo[31:0])
                      : (quo > DW'(32'h7FFFFFFF) ? 32'h7FFFFFFF : quo[31:0]);
   assign uv    = {ru_q[31], ru_q} + {rv_q[31], rv_q};
   assign hit   = !ru_q[31] && !rv_q[31] && uv <= ONE && rt_q >= T_EPS;
   always_comb begin
      state_d = state_q;
      a_d = a_q; nt_d = nt_q; nu_d = nu_q; nv_d = nv_q;
      rt_d = rt_q; ru_d = ru_q; rv_d = rv_q;
      ot_d = ot_q; ou_d = ou_q; ov_d = ov_q; hit_d = hit_q; oid_d = oid_q;
      rem_d = rem_q; dd_d = dd_q; cnt_d = cnt_q; idx_d = idx_q;
      deg_d = deg_q; id_d = id_q; busy_d = busy_q; valid_d = 1'b0;
      unique case (state_q)
         IDLE: if (i_en) begin
            a_d = i_det_a; nt_d = i_det_t; nu_d = i_det_u; nv_d = i_det_v;
            id_d = i_id;
            busy_d = 1'b1;
            deg_d = i_det_a == 32'sd0;
            state_d = i_det_a == 32'sd0 ? TEST : DIV;
            rem_d = '0; cnt_d = '0; idx_d = 2'd0;
            dd_d = {mag(i_det_t), {FRA_BITS{1'b0}}};
         end
         DIV: begin
            rem_d = ge ? diff[31:0] : trial[31:0];
            dd_d = quo;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               rt_d = idx_q == 2'd0 ? res : rt_q;
               ru_d = idx_q == 2'd1 ? res : ru_q;
               rv_d = idx_q == 2'd2 ? res : rv_q;
               rem_d = '0; cnt_d = '0; idx_d = idx_q + 2'd1;
               dd_d = {mag(nxt), {FRA_BITS{1'b0}}};
               state_d = idx_q == 2'd2 ? TEST : DIV;
            end
         end
         TEST: begin
            ot_d = deg_q ? '0 : rt_q;
            ou_d = deg_q ? '0 : ru_q;
            ov_d = deg_q ? '0 : rv_q;
            hit_d = !deg_q && hit;
            oid_d = id_q;
            valid_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         a_q <= '0; nt_q <= '0; nu_q <= '0; nv_q <= '0;
         rt_q <= '0; ru_q <= '0; rv_q <= '0;
         ot_q <= '0; ou_q <= '0; ov_q <= '0; hit_q <= 1'b0; oid_q <= '0;
         rem_q <= '0; dd_q <= '0; cnt_q <= '0; idx_q <= '0;
         deg_q <= 1'b0; id_q <= '0; busy_q <= 1'b0; valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d; nt_q <= nt_d; nu_q <= nu_d; nv_q <= nv_d;
         rt_q <= rt_d; ru_q <= ru_d; rv_q <= rv_d;
         ot_q <= ot_d; ou_q <= ou_d; ov_q <= ov_d; hit_q <= hit_d; oid_q <= oid_d;
         rem_q <= rem_d; dd_q <= dd_d; cnt_q <= cnt_d; idx_q <= idx_d;
         deg_q <= deg_d; id_q <= id_d; busy_q <= busy_d; valid_q <= valid_d;
      end
   end
   assign o_t = ot_q;
   assign o_u = ou_q;
   assign o_v = ov_q;
   assign o_hit = hit_q;
   assign o_id = oid_q;
   assign o_busy = busy_q;
   assign o_valid = valid_q;
endmodule

// File: tb/tb_fip_32_tri_hit.sv
// tb_fip_32_tri_hit: directed and randomized checks of the hit resolver
// against an arithmetic reference model.
module tb_fip_32_tri_hit;
   logic clk = 1'b0;
   logic rstn, en;
   logic signed [31:0] da, dt, du, dv;
   logic [15:0] id;
   logic signed [31:0] o_t, o_u, o_v;
   logic o_hit, o_busy, o_valid;
   logic [15:0] o_id;
   int checks = 0;
   int errors = 0;

   fip_32_tri_hit dut (
      .i_clk(clk), .i_rstn(rstn), .i_en(en),
      .i_det_a(da), .i_det_t(dt), .i_det_u(du), .i_det_v(dv), .i_id(id),
      .o_t(o_t), .o_u(o_u), .o_v(o_v), .o_hit(o_hit), .o_id(o_id),
      .o_busy(o_busy), .o_valid(o_valid)
   );

   always #5 clk = ~clk;

   function automatic logic signed [31:0] ref_q(input logic signed [31:0] n, input logic signed [31:0] a);
      longint q;
      if (a == 0) return 0;
      q = (longint'(n) * 65536) / longint'(a);
      if (q > 64'sh7FFFFFFF) return 32'sh7FFFFFFF;
      if (q < -64'sh80000000) return 32'sh80000000;
      return 32'(q);
   endfunction

   function automatic logic ref_hit(input logic signed [31:0] a, t, u, v);
      logic signed [31:0] qt, qu, qv;
      if (a == 0) return 1'b0;
      qt = ref_q(t, a); qu = ref_q(u, a); qv = ref_q(v, a);
      return qu >= 0 && qv >= 0 && (longint'(qu) + longint'(qv)) <= 65536 && qt >= 1;
   endfunction

   // Starts one operation and waits (bounded) for its o_valid; lat=-1 on timeout
   task automatic run_op(input logic signed [31:0] a, t, u, v, input logic [15:0] tag,
                         output logic signed [31:0] rt, ru, rv, output logic rh,
                         output logic [15:0] rid, output int lat);
      da = a; dt = t; du = u; dv = v; id = tag; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      da = $urandom; dt = $urandom; du = $urandom; dv = $urandom; id = 16'($urandom);
      lat = -1;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         if (o_valid) begin lat = c; break; end
      end
      rt = o_t; ru = o_u; rv = o_v; rh = o_hit; rid = o_id;
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b0; da = 0; dt = 0; du = 0; dv = 0; id = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({o_t, o_u, o_v, o_hit, o_id, o_busy, o_valid} !== '0) begin
         errors++; $display("FAIL reset_state got %h expected 0", {o_t, o_u, o_v, o_hit, o_id, o_busy, o_valid});
      end
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic signed [31:0] rt, ru, rv; logic rh; logic [15:0] rid; int lat;
      logic signed [31:0] held;
      run_op(32'sh00020000, 32'sh00060000, 32'sh00008000, 32'sh00010000, 16'd5, rt, ru, rv, rh, rid, lat);
      checks += 8;
      if (lat !== 145) begin errors++; $display("FAIL basic_latency got %0d expected 145", lat); end
      if (rt !== 32'sh00030000) begin errors++; $display("FAIL basic_t got %h expected 00030000", rt); end
      if (ru !== 32'sh00004000) begin errors++; $display("FAIL basic_u got %h expected 00004000", ru); end
      if (rv !== 32'sh00008000) begin errors++; $display("FAIL basic_v got %h expected 00008000", rv); end
      if (rh !== 1'b1) begin errors++; $display("FAIL basic_hit got %b expected 1", rh); end
      if (rid !== 16'd5) begin errors++; $display("FAIL basic_id got %0d expected 5", rid); end
      if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_with_valid got %b expected 0", o_busy); end
      held = o_t;
      @(posedge clk); #1;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle got %b expected 0", o_valid); end
      checks++;
      if (o_t !== held) begin errors++; $display("FAIL basic_hold got %h expected %h", o_t, held); end
   endtask

   task automatic test_sign();
      logic signed [31:0] rt, ru, rv; logic rh; logic [15:0] rid; int lat;
      run_op(-32'sh00020000, -32'sh00060000, -32'sh00008000, -32'sh00010000, 16'd6, rt, ru, rv, rh, rid, lat);
      checks += 4;
      if (rt !== 32'sh00030000) begin errors++; $display("FAIL sign_t got %h expected 00030000", rt); end
      if (ru !== 32'sh00004000) begin errors++; $display("FAIL sign_u got %h expected 00004000", ru); end
      if (rv !== 32'sh00008000) begin errors++; $display("FAIL sign_v got %h expected 00008000", rv); end
      if (rh !== 1'b1) begin errors++; $display("FAIL sign_hit got %b expected 1", rh); end
   endtask

   task automatic test_degenerate_miss();
      logic signed [31:0] tbl [3][4] = '{
         '{32'sh0, 32'sh00060000, 32'sh00008000, 32'sh00010000},
         '{32'sh00010000, 32'sh00010000, 32'sh0000C000, 32'sh00008000},
         '{32'sh00010000, -32'sh00010000, 32'sh0000C000, 32'sh00008000}};
      logic signed [31:0] rt, ru, rv; logic rh; logic [15:0] rid; int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 16'(20 + i), rt, ru, rv, rh, rid, lat);
         checks += 5;
         if (lat !== (i == 0 ? 1 : 145)) begin errors++; $display("FAIL miss%0d_latency got %0d expected %0d", i, lat, i == 0 ? 1 : 145); end
         if (rt !== ref_q(tbl[i][1], tbl[i][0])) begin errors++; $display("FAIL miss%0d_t got %h expected %h", i, rt, ref_q(tbl[i][1], tbl[i][0])); end
         if (ru !== ref_q(tbl[i][2], tbl[i][0])) begin errors++; $display("FAIL miss%0d_u got %h expected %h", i, ru, ref_q(tbl[i][2], tbl[i][0])); end
         if (rv !== ref_q(tbl[i][3], tbl[i][0])) begin errors++; $display("FAIL miss%0d_v got %h expected %h", i, rv, ref_q(tbl[i][3], tbl[i][0])); end
         if (rh !== 1'b0) begin errors++; $display("FAIL miss%0d_hit got %b expected 0", i, rh); end
      end
   endtask

   task automatic test_precision();
      logic signed [31:0] rt, ru, rv; logic rh; logic [15:0] rid; int lat;
      run_op(32'sd3, 32'sd0, 32'sd2, 32'sd0, 16'd30, rt, ru, rv, rh, rid, lat);
      checks++;
      if (ru !== 32'sh0000AAAA) begin errors++; $display("FAIL trunc_u got %h expected 0000aaaa", ru); end
      run_op(32'sd1, 32'sh7FFFFFFF, 32'sd0, 32'sd0, 16'd31, rt, ru, rv, rh, rid, lat);
      checks++;
      if (rt !== 32'sh7FFFFFFF) begin errors++; $display("FAIL sat_pos got %h expected 7fffffff", rt); end
      run_op(32'sd1, 32'sh80000000, 32'sd0, 32'sd0, 16'd32, rt, ru, rv, rh, rid, lat);
      checks++;
      if (rt !== 32'sh80000000) begin errors++; $display("FAIL sat_neg got %h expected 80000000", rt); end
   endtask

   task automatic test_ignored_en();
      int nval = 0, vc = -1;
      da = 32'sh00020000; dt = 32'sh00060000; du = 32'sh00008000; dv = 32'sh00010000; id = 16'd7; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (c == 10 || c == 60) begin
            da = 32'sd1; dt = 32'sd5; du = 32'sd0; dv = 32'sd0; id = 16'hBEEF; en = 1'b1;
         end
         @(posedge clk); #1;
         en = 1'b0;
         if (o_valid) begin nval++; if (vc < 0) vc = c; end
      end
      checks += 4;
      if (nval !== 1) begin errors++; $display("FAIL ignored_en_valid_count got %0d expected 1", nval); end
      if (vc !== 145) begin errors++; $display("FAIL ignored_en_latency got %0d expected 145", vc); end
      if (o_id !== 16'd7) begin errors++; $display("FAIL ignored_en_id got %h expected 0007", o_id); end
      if (o_t !== 32'sh00030000) begin errors++; $display("FAIL ignored_en_t got %h expected 00030000", o_t); end
   endtask

   task automatic test_back_to_back();
      logic signed [31:0] rt, ru, rv; logic rh; logic [15:0] rid; int lat;
      run_op(32'sh00010000, 32'sh00020000, 32'sh00004000, 32'sh00004000, 16'd40, rt, ru, rv, rh, rid, lat);
      run_op(32'sh00040000, 32'sh00080000, 32'sh00010000, 32'sh00010000, 16'd41, rt, ru, rv, rh, rid, lat);
      checks += 3;
      if (lat !== 145) begin errors++; $display("FAIL b2b_gap got %0d expected 145 (146 between strobes)", lat + 1); end
      if (rt !== 32'sh00020000) begin errors++; $display("FAIL b2b_t got %h expected 00020000", rt); end
      if (rid !== 16'd41) begin errors++; $display("FAIL b2b_id got %0d expected 41", rid); end
   endtask

   task automatic test_reset_mid();
      logic signed [31:0] rt, ru, rv; logic rh; logic [15:0] rid; int lat;
      int nval = 0;
      da = 32'sh00020000; dt = 32'sh00060000; du = 32'sh00008000; dv = 32'sh00010000; id = 16'd9; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (50) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      checks++;
      if ({o_t, o_u, o_v, o_hit, o_id, o_busy, o_valid} !== '0) begin
         errors++; $display("FAIL midreset_outputs got %h expected 0", {o_t, o_u, o_v, o_hit, o_id, o_busy, o_valid});
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (o_valid) nval++;
      end
      checks++;
      if (nval !== 0) begin errors++; $display("FAIL midreset_no_valid got %0d expected 0", nval); end
      run_op(32'sh00020000, 32'sh00060000, 32'sh00008000, 32'sh00010000, 16'd5, rt, ru, rv, rh, rid, lat);
      checks += 4;
      if (lat !== 145) begin errors++; $display("FAIL rerun_latency got %0d expected 145", lat); end
      if ({rt, ru, rv} !== {32'sh00030000, 32'sh00004000, 32'sh00008000}) begin
         errors++; $display("FAIL rerun_tuv got %h %h %h expected 00030000 00004000 00008000", rt, ru, rv);
      end
      if (rh !== 1'b1) begin errors++; $display("FAIL rerun_hit got %b expected 1", rh); end
      if (rid !== 16'd5) begin errors++; $display("FAIL rerun_id got %0d expected 5", rid); end
   endtask

   task automatic test_random();
      logic signed [31:0] a, t, u, v, rt, ru, rv; logic rh; logic [15:0] tag, rid; int lat;
      for (int i = 0; i < 24; i++) begin
         if (i % 5 == 4) begin
            a = $urandom; t = $urandom; u = $urandom; v = $urandom;
         end else begin
            a = 32'($urandom_range(32'h4000, 32'h40000));
            t = 32'($urandom_range(0, 32'h100000)) - 32'sh8000;
            u = 32'($urandom_range(0, 32'(a))) - 32'($urandom_range(0, 32'h1000));
            v = 32'($urandom_range(0, 32'(a) / 2));
            if ($urandom_range(0, 1) == 1) begin a = -a; t = -t; u = -u; v = -v; end
         end
         tag = 16'($urandom);
         run_op(a, t, u, v, tag, rt, ru, rv, rh, rid, lat);
         checks += 6;
         if (lat !== (a == 0 ? 1 : 145)) begin errors++; $display("FAIL rand%0d_latency got %0d", i, lat); end
         if (rt !== ref_q(t, a)) begin errors++; $display("FAIL rand%0d_t got %h expected %h", i, rt, ref_q(t, a)); end
         if (ru !== ref_q(u, a)) begin errors++; $display("FAIL rand%0d_u got %h expected %h", i, ru, ref_q(u, a)); end
         if (rv !== ref_q(v, a)) begin errors++; $display("FAIL rand%0d_v got %h expected %h", i, rv, ref_q(v, a)); end
         if (rh !== ref_hit(a, t, u, v)) begin errors++; $display("FAIL rand%0d_hit got %b expected %b", i, rh, ref_hit(a, t, u, v)); end
         if (rid !== tag) begin errors++; $display("FAIL rand%0d_id got %h expected %h", i, rid, tag); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sign();
      test_degenerate_miss();
      test_precision();
      test_ignored_en();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fip_32_tri_hit.md
# fip_32_tri_hit

Ray–triangle hit resolver for the Q16.16 ray tracer. It sits directly downstream of `fip_32_3b3_det`. It takes the four Cramer's-rule determinants for one ray/triangle pair: the system determinant and the t, u, v numerators. It produces t, u, v through one shared sequential restoring divider, then flags a hit when the barycentric and distance tests pass.

## Interface

Parameters:
- `FRA_BITS`, 16: fractional bits (Q16.16).
- `ID_W`, 16: width of the pass-through triangle tag.
- `T_EPS`, 32'sd1: minimum t counted as a hit (Q16.16, signed).

Ports:
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `i_en`, in, 1: start request; accepted only while `o_busy`=0.
- `i_det_a`, in, 32 signed: system determinant (divisor).
- `i_det_t`, in, 32 signed: t numerator.
- `i_det_u`, in, 32 signed: u numerator.
- `i_det_v`, in, 32 signed: v numerator.
- `i_id`, in, `ID_W`: triangle tag, latched on accept.
- `o_t`, out, 32 signed: t = det_t/det_a.
- `o_u`, out, 32 signed: u = det_u/det_a.
- `o_v`, out, 32 signed: v = det_v/det_a.
- `o_hit`, out, 1: hit flag, qualified by `o_valid`.
- `o_id`, out, `ID_W`: tag of the result.
- `o_busy`, out, 1: operation in progress.
- `o_valid`, out, 1: one-cycle result strobe.

## Operation

State machine: IDLE → DIV → TEST → IDLE.

IDLE:
- On `i_en`=1, latch all inputs and the tag, and set `o_busy`=1.
- If det_a ≠ 0, go to DIV with quotient index 0 (t).
- If det_a = 0, go to TEST with the degenerate flag set.

DIV:
- Divisor is |det_a| (32 b). Dividend is |num| << FRA_BITS (48 b).
- Unsigned restoring division, one quotient bit per cycle, 48 iterations, MSB first.
- On the final iteration of each quotient, the result is written in the same edge:
  - Sign is sign(num) XOR sign(det_a).
  - The result truncates toward zero.
  - Saturation: positive magnitude > 0x7FFFFFFF gives 0x7FFFFFFF; negative magnitude > 0x80000000 gives 0x80000000.
  - The next index (u, then v) is loaded in that same edge.
- After v is written, go to TEST.

TEST:
- hit = (u ≥ 0) & (v ≥ 0) & (u+v ≤ 1<<FRA_BITS) & (t ≥ T_EPS). The u+v sum is computed 33-bit signed, with no wrap.
- Degenerate case: hit=0 and t/u/v = 0.
- Register the outputs, pulse `o_valid`, clear `o_busy`, and go to IDLE.

Handshake and ordering:
- `i_en` while `o_busy`=1 is ignored; inputs are not latched and nothing is queued.
- The holder keeps inputs stable only for the accept cycle.
- Outputs hold their value until the next TEST write.
- `o_id` always matches the latched tag.

Reset:
- Asynchronous assert at any time, including mid-DIV: state → IDLE, and all outputs → 0 (`o_t`, `o_u`, `o_v`, `o_hit`, `o_id`, `o_busy`, `o_valid`).
- The aborted operation produces no `o_valid`.

## Timing

- Accept edge k (`i_en`=1, `o_busy`=0): `o_busy`=1 from after edge k.
- Non-degenerate case:
  - DIV occupies edges k+1 … k+144 (3 × 48).
  - TEST is at edge k+145, and `o_valid`=1 for exactly the cycle after edge k+145.
  - Latency is 145 cycles; throughput is 1 result per 146 cycles.
- Degenerate case (det_a = 0): TEST at edge k+1, and `o_valid` is high in the following cycle.
- `o_busy` falls in the same edge that `o_valid` rises. An `i_en` presented during the `o_valid` cycle is accepted, so back-to-back operation has no gap cycle.
- `o_valid` is never high for two consecutive cycles.
- `o_valid` and `o_busy` are never simultaneously 1.

## Test plan

1. **Basic hit:** det_a=0x00020000, det_t=0x00060000, det_u=0x00008000, det_v=0x00010000, id=5. Required: after 145 cycles `o_valid` pulses with t=0x00030000, u=0x00004000, v=0x00008000, hit=1, id=5.
2. **Sign handling:** all four determinants of scenario 1 negated (det_a=0xFFFE0000, …). Required: identical t/u/v, hit=1.
3. **Degenerate and misses:**
   - det_a=0: `o_valid` one cycle after accept, t=u=v=0, hit=0.
   - det_a=0x00010000, det_u=0x0000C000, det_v=0x00008000, det_t=0x00010000: u+v>1.0, so hit=0.
   - Same with det_t=0xFFFF0000: t<0, so hit=0.
4. **Precision and saturation:**
   - det_a=3, det_u=2: u=0x0000AAAA (43690, truncated).
   - det_a=1, det_t=0x7FFFFFFF: t=0x7FFFFFFF.
   - det_a=1, det_t=0x80000000: t=0x80000000.
5. **Handshake:**
   - `i_en` pulses at cycles 10 and 60 after an accept: ignored, exactly one `o_valid`.
   - A second `i_en` held during the `o_valid` cycle: accepted, and the next `o_valid` arrives 146 cycles after the first.
6. **Reset:** `i_rstn` low for 1 cycle at cycle 50 of a division. Required: all outputs 0 immediately and no `o_valid`. Scenario 1 rerun afterwards gives the correct result.
